fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Controller for the in-place radix-2 decimation-in-time FFT datapath. On `start`, it steps through all LOG2N stages and all N/2 butterflies per stage. For each butterfly it issues the operand addresses and twiddle index to the butterfly unit and memory. It then delays those addresses by the butterfly latency to drive the write-back port. Between stages it flushes the butterfly pipeline so no stage reads data the previous stage has not yet written.

## Interface
- `LOG2N`, default 5: log2 of transform size N (N = 32 by default).
- `BF_LAT`, default 2: butterfly latency in cycles from issue to result, ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `clr_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `hold`  in  1  stall issue (see Configuration).
- `busy`  out  1  high from first issue cycle through last write-back cycle.
- `done`  out  1  one-cycle pulse after the final write-back.
- `stage`  out  LOG2N-width (bits sized to hold LOG2N-1)  current stage index.
- `bf_valid`  out  1  issue strobe.
- `addr_a`, `addr_b`  out  LOG2N each  operand read addresses.
- `tw_idx`  out  LOG2N-1  twiddle ROM index.
- `wr_valid`  out  1  write-back strobe.
- `wr_addr_a`, `wr_addr_b`  out  LOG2N each  write-back addresses.

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → FLUSH after issuing butterfly j = N/2-1.
  - FLUSH → RUN with `stage` incremented when the flush count reaches BF_LAT and `stage` < LOG2N-1.
  - FLUSH → DONE when the flush count reaches BF_LAT and `stage` = LOG2N-1.
  - DONE → IDLE unconditionally.
- Butterfly counter j is a wrap-around counter over 0..N/2-1. It is cleared on entry to RUN and increments once per issue.
- Address arithmetic for stage s, with half = 2^s:
  - pos = j mod half.
  - grp = j >> s.
  - addr_a = (grp << (s+1)) | pos.
  - addr_b = addr_a + half.
  - tw_idx = pos << (LOG2N-1-s), truncated to LOG2N-1 bits.
- `bf_valid` is 1 only in RUN cycles that issue.
- Delay line: a BF_LAT-deep shift register of {valid, addr_a, addr_b}. It shifts every cycle regardless of state or `hold`. Its output drives `wr_valid`, `wr_addr_a` and `wr_addr_b`.
- All outputs are registered.
- `start` while not in IDLE is ignored.
- `clr_n` low at any time, including mid-transform:
  - FSM goes to IDLE.
  - j, `stage`, flush counter and delay line go to 0.
  - All outputs go to 0; in-flight write-backs are discarded.
- Outputs in IDLE: `bf_valid`/`wr_valid` = 0. Address outputs hold their last value; they are don't-care when their strobe is low.

## Timing
- `start` sampled at edge k: first `bf_valid` (stage 0, j=0, addr_a=0, addr_b=1, tw_idx=0) appears in cycle k+1, and `busy` rises in that cycle.
- The write-back for an issue in cycle c appears in cycle c+BF_LAT.
- Stage period without hold is exactly N/2 + BF_LAT cycles. The next stage's first issue appears in the cycle after the previous stage's last `wr_valid`.
- Default parameters: issues in cycles 1–16 and flush in 17–18. The last `wr_valid` is in cycle 90, `busy` falls after cycle 90, and `done` = 1 in cycle 91.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `FFT_SEQ_HOLD_EN` defined:
  - `hold`=1 in RUN suppresses issue: `bf_valid`=0 and j/state frozen.
  - The delay line still shifts.
  - Each held RUN cycle extends the transform by one cycle.
  - `hold` in IDLE/FLUSH/DONE has no effect.
- Not defined: `hold` is ignored; the port stays present.

## Test plan
- Reset, then `start` at edge 0 with defaults → `bf_valid` in cycles 1–16 and 19–34; `wr_valid` in cycles 3–18; `done` only in cycle 91; `busy` high in cycles 1–90.
- Stage 2, j=5 → addr_a=9, addr_b=13, tw_idx=4.
- Stage 4, j=15 → addr_a=15, addr_b=31, tw_idx=15.
- `start` pulsed in cycle 40 mid-transform → ignored; `done` is still in cycle 91.
- `clr_n` low in cycle 25 → all outputs 0 immediately; no `wr_valid` or `done` afterwards; a later `start` restarts from stage 0, j=0.
- `FFT_SEQ_HOLD_EN` defined with `hold`=1 in cycles 5–7 → j=4 issues in cycle 8; `done` in cycle 94. Macro not defined → `done` in cycle 91.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: address/control sequencer for an in-place radix-2 DIT FFT.
// Walks LOG2N stages of N/2 butterflies each. For every butterfly it issues the
// operand addresses and twiddle index, then replays the addresses BF_LAT cycles
// later on the write-back port. Each stage ends with a BF_LAT-cycle flush so the
// next stage never reads a location that is still in the butterfly pipeline.
// Optional feature macro: FFT_SEQ_HOLD_EN (when defined, `hold` stalls issue in RUN).
module fft_stage_sequencer #(
  parameter int LOG2N  = 5,
  parameter int BF_LAT = 2
) (
  input  logic                                         clk,
  input  logic                                         clr_n,
  input  logic                                         start,
  input  logic                                         hold,
  output logic                                         busy,
  output logic                                         done,
  output logic [((LOG2N > 1) ? $clog2(LOG2N) : 1)-1:0] stage,
  output logic                                         bf_valid,
  output logic [LOG2N-1:0]                             addr_a,
  output logic [LOG2N-1:0]                             addr_b,
  output logic [LOG2N-2:0]                             tw_idx,
  output logic                                         wr_valid,
  output logic [LOG2N-1:0]                             wr_addr_a,
  output logic [LOG2N-1:0]                             wr_addr_b
);

  // Butterflies per stage, j / twiddle width, stage width, flush counter width.
  localparam int NH = 1 << (LOG2N - 1);
  localparam int JW = LOG2N - 1;
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int FW = $clog2(BF_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  // r_j is the butterfly issued in this cycle, or the one waiting to issue
  // when this cycle was stalled.
  logic [JW-1:0]     r_j;
  logic [JW-1:0]     w_j_next;
  logic [SW-1:0]     r_stage;
  logic [SW-1:0]     w_stage_next;
  logic [FW-1:0]     r_flush_cnt;
  logic [FW-1:0]     w_flush_cnt_next;
  logic              w_issue_next;
  logic              w_hold_eff;

  // Registered issue-side outputs.
  logic              r_bf_valid;
  logic              r_busy;
  logic              r_done;
  logic [LOG2N-1:0]  r_addr_a;
  logic [LOG2N-1:0]  r_addr_b;
  logic [JW-1:0]     r_tw_idx;

  // Address arithmetic for the butterfly about to be issued.
  logic [JW-1:0]     w_mask;
  logic [JW-1:0]     w_pos;
  logic [JW-1:0]     w_hi;
  logic [SW-1:0]     w_tw_shift;
  logic [LOG2N-1:0]  w_addr_a_next;
  logic [LOG2N-1:0]  w_addr_b_next;
  logic [JW-1:0]     w_tw_next;

  // Delay line taps: index 0 is the issue port, index BF_LAT the write-back port.
  logic [BF_LAT:0]              w_dl_valid;
  logic [BF_LAT:0][LOG2N-1:0]   w_dl_a;
  logic [BF_LAT:0][LOG2N-1:0]   w_dl_b;

`ifdef FFT_SEQ_HOLD_EN
  assign w_hold_eff = hold;
`else
  // Stall feature compiled out: the port remains but never affects issue.
  assign w_hold_eff = hold & 1'b0;
`endif

  // FSM state, butterfly counter, stage index and flush counter.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= S_IDLE;
      r_j         <= '0;
      r_stage     <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_j         <= w_j_next;
      r_stage     <= w_stage_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  // Next-state logic; also decides whether the next cycle issues a butterfly.
  always_comb begin
    w_state_next     = r_state;
    w_j_next         = r_j;
    w_stage_next     = r_stage;
    w_flush_cnt_next = r_flush_cnt;
    w_issue_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_j_next     = '0;
          w_stage_next = '0;
          w_issue_next = 1'b1;
        end
      end
      S_RUN: begin
        if (r_bf_valid && (r_j == JW'(NH - 1))) begin
          // Last butterfly of the stage just went out: drain the pipeline.
          w_state_next     = S_FLUSH;
          w_flush_cnt_next = FW'(1);
          w_j_next         = '0;
        end else begin
          // Advance only past a butterfly that actually issued; a stalled
          // cycle keeps the pending j.
          if (r_bf_valid) begin
            w_j_next = r_j + JW'(1);
          end
          w_issue_next = !w_hold_eff;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == FW'(BF_LAT)) begin
          w_flush_cnt_next = '0;
          if (r_stage == SW'(LOG2N - 1)) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_RUN;
            w_stage_next = r_stage + SW'(1);
            w_j_next     = '0;
            w_issue_next = 1'b1;
          end
        end else begin
          w_flush_cnt_next = r_flush_cnt + FW'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Insert a zero at bit `stage` of j to form addr_a; addr_b sets that bit.
  // The twiddle index is the in-group position scaled up to the N/2 grid.
  always_comb begin
    w_mask        = ~({JW{1'b1}} << w_stage_next);
    w_pos         = w_j_next & w_mask;
    w_hi          = w_j_next & ~w_mask;
    w_addr_a_next = {w_hi, 1'b0} | {1'b0, w_pos};
    w_addr_b_next = w_addr_a_next | (LOG2N'(1) << w_stage_next);
    w_tw_shift    = SW'(JW) - w_stage_next;
    w_tw_next     = w_pos << w_tw_shift;
  end

  // Issue-side output registers; addresses hold their value between issues.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_bf_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_tw_idx   <= '0;
    end else begin
      r_bf_valid <= w_issue_next;
      r_busy     <= (w_state_next == S_RUN) || (w_state_next == S_FLUSH);
      r_done     <= (w_state_next == S_DONE);
      if (w_issue_next) begin
        r_addr_a <= w_addr_a_next;
        r_addr_b <= w_addr_b_next;
        r_tw_idx <= w_tw_next;
      end
    end
  end

  assign w_dl_valid[0] = r_bf_valid;
  assign w_dl_a[0]     = r_addr_a;
  assign w_dl_b[0]     = r_addr_b;

  // Write-back delay line; shifts every cycle irrespective of state or stall.
  genvar gi;
  generate
    for (gi = 0; gi < BF_LAT; gi++) begin : g_dl
      logic             r_v;
      logic [LOG2N-1:0] r_a;
      logic [LOG2N-1:0] r_b;

      // One pipeline slot of {valid, addr_a, addr_b}.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          r_v <= 1'b0;
          r_a <= '0;
          r_b <= '0;
        end else begin
          r_v <= w_dl_valid[gi];
          r_a <= w_dl_a[gi];
          r_b <= w_dl_b[gi];
        end
      end

      assign w_dl_valid[gi+1] = r_v;
      assign w_dl_a[gi+1]     = r_a;
      assign w_dl_b[gi+1]     = r_b;
    end
  endgenerate

  assign busy      = r_busy;
  assign done      = r_done;
  assign stage     = r_stage;
  assign bf_valid  = r_bf_valid;
  assign addr_a    = r_addr_a;
  assign addr_b    = r_addr_b;
  assign tw_idx    = r_tw_idx;
  assign wr_valid  = w_dl_valid[BF_LAT];
  assign wr_addr_a = w_dl_a[BF_LAT];
  assign wr_addr_b = w_dl_b[BF_LAT];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer. Stimulus (start, hold, reset) is laid out per
// clock edge up front; whenever a start is accepted the bench lays out the whole
// expected transform timeline from the butterfly schedule, and a negedge process
// compares every cycle against it. Cycle c is the interval ending at edge c.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  localparam int LOG2N  = 5;
  localparam int BF_LAT = 2;
  localparam int NH     = 1 << (LOG2N - 1);
  localparam int SW     = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int MAXC   = 3000;
  localparam int NCYC   = 2800;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             start;
  logic             hold;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             bf_valid;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_valid;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .bf_valid  (bf_valid),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .wr_valid  (wr_valid),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  // Stimulus per edge / per cycle.
  bit start_e [MAXC];
  bit hold_e  [MAXC];
  bit rst_c   [MAXC];

  // Expected outputs per cycle.
  bit exp_bf   [MAXC];
  bit exp_wr   [MAXC];
  bit exp_busy [MAXC];
  bit exp_done [MAXC];
  int exp_a    [MAXC];
  int exp_b    [MAXC];
  int exp_tw   [MAXC];
  int exp_st   [MAXC];
  int exp_j    [MAXC];
  int exp_wa   [MAXC];
  int exp_wb   [MAXC];

  int free_edge;
  int ec;
  int n_cmp;
  int n_bad;

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d want %0d", nm, c, act, want);
    end
  endtask

  function automatic bit hold_eff(input int e);
`ifdef FFT_SEQ_HOLD_EN
    return hold_e[e];
`else
    return hold_e[e] & 1'b0;
`endif
  endfunction

  // Lay out the full transform started at edge k.
  task automatic build(input int k);
    int t;
    int half;
    int pos;
    int grp;
    int a;
    t = k + 1;
    for (int s = 0; s < LOG2N; s++) begin
      half = 1 << s;
      for (int j = 0; j < NH; j++) begin
        if (j > 0) begin
          while (t < MAXC - 1 && hold_eff(t - 1)) t++;
        end
        pos = j % half;
        grp = j / half;
        a   = grp * 2 * half + pos;
        if (t < MAXC) begin
          exp_bf[t] = 1'b1;
          exp_a[t]  = a;
          exp_b[t]  = a + half;
          exp_tw[t] = pos * (1 << (LOG2N - 1 - s));
          exp_st[t] = s;
          exp_j[t]  = j;
        end
        if (t + BF_LAT < MAXC) begin
          exp_wr[t + BF_LAT] = 1'b1;
          exp_wa[t + BF_LAT] = a;
          exp_wb[t + BF_LAT] = a + half;
        end
        t++;
      end
      t += BF_LAT;
    end
    if (t < MAXC) exp_done[t] = 1'b1;
    for (int c = k + 1; c < t && c < MAXC; c++) exp_busy[c] = 1'b1;
    free_edge = t + 1;
  endtask

  // Reset in cycle c discards everything from that cycle on.
  task automatic wipe(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_bf[i] = 0; exp_wr[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
      exp_a[i] = 0; exp_b[i] = 0; exp_tw[i] = 0; exp_st[i] = 0;
      exp_j[i] = 0; exp_wa[i] = 0; exp_wb[i] = 0;
    end
    free_edge = c + 1;
  endtask

  // Per-cycle comparison against the timeline.
  initial begin
    int c;
    forever begin
      @(negedge clk);
      c = ec + 1;
      if (c < MAXC) begin
        if (!clr_n) begin
          check("reset_outputs", c,
                32'({busy, done, bf_valid, wr_valid, addr_a, addr_b,
                     wr_addr_a, wr_addr_b, tw_idx, stage}), 32'd0);
        end else begin
          check("busy", c, 32'(busy), 32'(exp_busy[c]));
          check("done", c, 32'(done), 32'(exp_done[c]));
          check("bf_valid", c, 32'(bf_valid), 32'(exp_bf[c]));
          check("wr_valid", c, 32'(wr_valid), 32'(exp_wr[c]));
          if (exp_bf[c]) begin
            check("addr_a", c, 32'(addr_a), 32'(exp_a[c]));
            check("addr_b", c, 32'(addr_b), 32'(exp_b[c]));
            check("tw_idx", c, 32'(tw_idx), 32'(exp_tw[c]));
            check("stage", c, 32'(stage), 32'(exp_st[c]));
          end
          if (exp_wr[c]) begin
            check("wr_addr_a", c, 32'(wr_addr_a), 32'(exp_wa[c]));
            check("wr_addr_b", c, 32'(wr_addr_b), 32'(exp_wb[c]));
          end
        end
      end
    end
  end

  // Stimulus driver, model update and final literal pins.
  initial begin
    int cnt;
    n_cmp = 0; n_bad = 0; ec = 0; free_edge = 0;
    clr_n = 1'b0; start = 1'b0; hold = 1'b0;

    for (int i = 1; i <= 3; i++) rst_c[i] = 1'b1;
    start_e[5]   = 1'b1;                       // transform 1
    start_e[45]  = 1'b1;                       // ignored mid-transform
    start_e[100] = 1'b1;                       // transform 2 with stall
    for (int i = 104; i <= 106; i++) hold_e[i] = 1'b1;
    start_e[200] = 1'b1;                       // transform 3, reset in cycle 225
    rst_c[225]   = 1'b1;
    start_e[260] = 1'b1;                       // restart after reset
    for (int e = 360; e <= 2400; e++) begin
      start_e[e] = ($urandom_range(0, 5) == 0);
      hold_e[e]  = ($urandom_range(0, 3) == 0);
      rst_c[e]   = ($urandom_range(0, 699) == 0);
    end

    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      ec = ec + 1;
      if (start_e[ec] && !rst_c[ec] && ec >= free_edge) build(ec);
      if (rst_c[ec + 1]) wipe(ec + 1);
      #1;
      start = start_e[ec + 1];
      hold  = hold_e[ec + 1];
      clr_n = 1'b1;
      if (rst_c[ec + 1]) begin
        #1;
        clr_n = 1'b0;
      end
    end

    // Hand-computed pins on the model timeline.
    cnt = 0;
    for (int c = 6; c <= 21; c++) cnt += int'(exp_bf[c]);
    check("pin_stage0_issues", 6, 32'(cnt), 32'd16);
    check("pin_flush_gap", 22, 32'(exp_bf[22] | exp_bf[23]), 32'd0);
    check("pin_stage1_first", 24, 32'(exp_st[24]), 32'd1);
    check("pin_wr_first", 8, 32'({exp_wr[7], exp_wr[8]}), 32'd1);
    check("pin_wr_last", 95, 32'({exp_wr[95], exp_wr[96]}), 32'd2);
    cnt = 0;
    for (int c = 6; c <= 99; c++) cnt += int'(exp_done[c]);
    check("pin_done_count", 96, 32'(cnt), 32'd1);
    check("pin_done_cycle", 96, 32'(exp_done[96]), 32'd1);
    check("pin_busy_edges", 96, 32'({exp_busy[5], exp_busy[6], exp_busy[95], exp_busy[96]}), 32'b0110);
    check("pin_s2j5_a", 47, 32'(exp_a[47]), 32'd9);
    check("pin_s2j5_b", 47, 32'(exp_b[47]), 32'd13);
    check("pin_s2j5_tw", 47, 32'(exp_tw[47]), 32'd4);
    check("pin_s2j5_j", 47, 32'(exp_j[47]), 32'd5);
    check("pin_s4j15_a", 93, 32'(exp_a[93]), 32'd15);
    check("pin_s4j15_b", 93, 32'(exp_b[93]), 32'd31);
    check("pin_s4j15_tw", 93, 32'(exp_tw[93]), 32'd15);
`ifdef FFT_SEQ_HOLD_EN
    check("pin_hold_j4", 108, 32'(exp_j[108]), 32'd4);
    check("pin_hold_gap", 105, 32'(exp_bf[105]), 32'd0);
    check("pin_hold_done", 194, 32'(exp_done[194]), 32'd1);
`else
    check("pin_nohold_j4", 105, 32'(exp_j[105]), 32'd4);
    check("pin_nohold_done", 191, 32'(exp_done[191]), 32'd1);
`endif
    cnt = 0;
    for (int c = 225; c <= 260; c++) cnt += int'(exp_wr[c]) + int'(exp_done[c]) + int'(exp_busy[c]);
    check("pin_after_reset_quiet", 225, 32'(cnt), 32'd0);
    check("pin_restart_a", 261, 32'({exp_bf[261], exp_st[261][2:0], exp_a[261][4:0]}), 32'h100);
    check("pin_restart_done", 351, 32'(exp_done[351]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
